// File: rtl/dpram_frame_writer_pkg.sv
// Shared defaults and FSM state encoding for the clk1-side frame writer
// in front of dual_port_RAM_CDC.
package dpram_frame_writer_pkg;

  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_ADDR_W      = 10;
  localparam int unsigned DEF_MAX_LEN     = 256;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DRAIN,
    ST_COMMIT,
    ST_WAIT_ACK,
    ST_WAIT_REL
  } wr_state_e;

endpackage

// File: rtl/dpram_frame_writer_cdc_sync_bit.sv
// Multi-flop single-bit synchroniser with asynchronous active-low reset.
module cdc_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dpram_frame_writer.sv
// Writes valid/ready framed byte stream into a ring buffer and publishes a
// frame descriptor to the clk2 reader over a 4-phase req/ack handshake.
module dpram_frame_writer
  import dpram_frame_writer_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_last,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            addr_1,
  output logic [DATA_W-1:0]            data_1,
  output logic                         desc_req,
  output logic [ADDR_W-1:0]            desc_base,
  output logic [$clog2(MAX_LEN+1)-1:0] desc_len,
  output logic                         desc_trunc,
  input  logic                         desc_ack
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  wr_state_e         state;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              trunc;
  logic              ack_s;
  logic              beat_acc;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk  (clk1),
    .rst_n(rst_n),
    .d    (desc_ack),
    .q    (ack_s)
  );

  // IDLE also waits for the previous ack to be released so a stale ack
  // cannot complete the next handshake early.
  always_comb begin
    s_ready = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_IDLE:  s_ready = !ack_s;
        ST_WRITE,
        ST_DRAIN: s_ready = 1'b1;
        default:  s_ready = 1'b0;
      endcase
    end
  end

  assign beat_acc = s_valid && s_ready;
  assign cnt_nxt  = cnt + 1'b1;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wp         <= '0;
      base       <= '0;
      cnt        <= '0;
      trunc      <= 1'b0;
      wr_en      <= 1'b0;
      addr_1     <= '0;
      data_1     <= '0;
      desc_req   <= 1'b0;
      desc_base  <= '0;
      desc_len   <= '0;
      desc_trunc <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (beat_acc) begin
            wr_en  <= 1'b1;
            addr_1 <= wp;
            data_1 <= s_data;
            wp     <= wp + 1'b1;
            base   <= wp;
            cnt    <= LEN_W'(1);
            trunc  <= 1'b0;
            if (s_last) begin
              state <= ST_COMMIT;
            end else if (MAX_LEN == 1) begin
              state <= ST_DRAIN;
              trunc <= 1'b1;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (beat_acc) begin
            wr_en  <= 1'b1;
            addr_1 <= wp;
            data_1 <= s_data;
            wp     <= wp + 1'b1;
            cnt    <= cnt_nxt;
            if (s_last) begin
              state <= ST_COMMIT;
            end else if (cnt_nxt == LEN_W'(MAX_LEN)) begin
              state <= ST_DRAIN;
              trunc <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (beat_acc && s_last) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          desc_base  <= base;
          desc_len   <= cnt;
          desc_trunc <= trunc;
          desc_req   <= 1'b1;
          state      <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_s) begin
            desc_req <= 1'b0;
            state    <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (!ack_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_frame_writer.sv
// Directed bench for dpram_frame_writer (MAX_LEN=4 to reach truncation).
module tb_dpram_frame_writer;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned MAX_LEN     = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LEN_W       = 3;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] data_1;
  logic              desc_req;
  logic [ADDR_W-1:0] desc_base;
  logic [LEN_W-1:0]  desc_len;
  logic              desc_trunc;
  logic              desc_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [DATA_W-1:0] wq_data[$];
  logic              overlap_seen = 1'b0;
  logic [DATA_W-1:0] frame_data[16];
  logic [ADDR_W-1:0] wp_model;

  dpram_frame_writer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .MAX_LEN    (MAX_LEN),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .wr_en     (wr_en),
    .addr_1    (addr_1),
    .data_1    (data_1),
    .desc_req  (desc_req),
    .desc_base (desc_base),
    .desc_len  (desc_len),
    .desc_trunc(desc_trunc),
    .desc_ack  (desc_ack)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    if (wr_en) begin
      wq_addr.push_back(addr_1);
      wq_data.push_back(data_1);
    end
    if (wr_en && desc_req) overlap_seen = 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: s_ready=%b required 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_beat(frame_data[i], i == n - 1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!desc_req && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (desc_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_req_rise: desc_req=%b required 1", tag, desc_req);
    end
  endtask

  task automatic reader(input logic [ADDR_W-1:0] eb, input logic [LEN_W-1:0] el,
                        input logic et, input string tag);
    int n = 0;
    wait_req(tag);
    checks++;
    if (desc_base !== eb) begin
      errors++;
      $display("FAIL %s_base: got %0d required %0d", tag, desc_base, eb);
    end
    checks++;
    if (desc_len !== el) begin
      errors++;
      $display("FAIL %s_len: got %0d required %0d", tag, desc_len, el);
    end
    checks++;
    if (desc_trunc !== et) begin
      errors++;
      $display("FAIL %s_trunc: got %b required %b", tag, desc_trunc, et);
    end
    desc_ack = 1'b1;
    while (desc_req && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (desc_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_req_fall: desc_req=%b required 0", tag, desc_req);
    end
    desc_ack = 1'b0;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: s_ready=%b required 1", tag, s_ready);
    end
  endtask

  task automatic check_writes(input logic [ADDR_W-1:0] base, input int n, input string tag);
    logic [ADDR_W-1:0] ea;
    checks++;
    if (wq_addr.size() != n) begin
      errors++;
      $display("FAIL %s_wr_count: got %0d required %0d", tag, wq_addr.size(), n);
    end
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      ea = base + ADDR_W'(i);
      checks++;
      if (wq_addr[i] !== ea || wq_data[i] !== frame_data[i]) begin
        errors++;
        $display("FAIL %s_wr%0d: got addr %0d data %h required addr %0d data %h",
                 tag, i, wq_addr[i], wq_data[i], ea, frame_data[i]);
      end
    end
    checks++;
    if (overlap_seen !== 1'b0) begin
      errors++;
      $display("FAIL %s_req_overlap: wr_en with desc_req seen=%b required 0", tag, overlap_seen);
    end
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_ready !== 1'b0 || wr_en !== 1'b0 || desc_req !== 1'b0 || addr_1 !== '0) begin
        errors++;
        $display("FAIL reset_hold: s_ready=%b wr_en=%b desc_req=%b addr_1=%0d required 0 0 0 0",
                 s_ready, wr_en, desc_req, addr_1);
      end
    end
    s_valid = 1'b0;
    rst_n   = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
    end
    tick();
    frame_data[0] = 8'h11;
    frame_data[1] = 8'h22;
    send_frame(2);
    reader(10'd0, 3'd2, 1'b0, "first");
    check_writes(10'd0, 2, "first");
    frame_data[0] = 8'h33;
    frame_data[1] = 8'h44;
    frame_data[2] = 8'h55;
    send_frame(3);
    reader(10'd2, 3'd3, 1'b0, "second");
    check_writes(10'd2, 3, "second");
  endtask

  task automatic test_frame();
    frame_data[0] = 8'hA5;
    frame_data[1] = 8'h3C;
    frame_data[2] = 8'h5A;
    send_frame(3);
    reader(10'd5, 3'd3, 1'b0, "frame");
    check_writes(10'd5, 3, "frame");
  endtask

  task automatic test_truncation();
    for (int i = 0; i < 6; i++) frame_data[i] = 8'(i + 1);
    send_frame(6);
    reader(10'd8, 3'd4, 1'b1, "trunc");
    check_writes(10'd8, 4, "trunc");
  endtask

  task automatic test_backpressure();
    frame_data[0] = 8'h11;
    send_frame(1);
    wait_req("bp");
    s_valid = 1'b1;
    s_data  = 8'h77;
    s_last  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (s_ready !== 1'b0 || wr_en !== 1'b0 || desc_req !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: s_ready=%b wr_en=%b desc_req=%b required 0 0 1",
                 i, s_ready, wr_en, desc_req);
      end
    end
    desc_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (desc_req !== (i < 3)) begin
        errors++;
        $display("FAIL bp_ack_edge%0d: desc_req=%b required %b", i, desc_req, i < 3);
      end
    end
    desc_ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (s_ready !== (i == 3)) begin
        errors++;
        $display("FAIL bp_release_edge%0d: s_ready=%b required %b", i, s_ready, i == 3);
      end
    end
    send_beat(8'h77, 1'b1);
    reader(10'd13, 3'd1, 1'b0, "bp_next");
    frame_data[1] = 8'h77;
    check_writes(10'd12, 2, "bp");
  endtask

  task automatic test_wrap();
    wp_model = 10'd14;
    while (wp_model != 10'd1022) begin
      for (int i = 0; i < 4; i++) frame_data[i] = 8'(wp_model) + 8'(i);
      send_frame(4);
      reader(wp_model, 3'd4, 1'b0, "fill");
      check_writes(wp_model, 4, "fill");
      wp_model = wp_model + 10'd4;
    end
    for (int i = 0; i < 4; i++) frame_data[i] = 8'hC1 + 8'(i);
    send_frame(4);
    reader(10'd1022, 3'd4, 1'b0, "wrap");
    check_writes(10'd1022, 4, "wrap");
    frame_data[0] = 8'hD0;
    send_frame(1);
    reader(10'd2, 3'd1, 1'b0, "wrap_next");
    check_writes(10'd2, 1, "wrap_next");
  endtask

  task automatic test_reset_mid_frame();
    send_beat(8'hD1, 1'b0);
    send_beat(8'hD2, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || addr_1 !== '0 || data_1 !== '0 || desc_req !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: wr_en=%b addr_1=%0d data_1=%h desc_req=%b s_ready=%b required all 0",
               wr_en, addr_1, data_1, desc_req, s_ready);
    end
    tick();
    tick();
    wq_addr.delete();
    wq_data.delete();
    rst_n = 1'b1;
    tick();
    frame_data[0] = 8'hE1;
    frame_data[1] = 8'hE2;
    send_frame(2);
    reader(10'd0, 3'd2, 1'b0, "after_reset");
    check_writes(10'd0, 2, "after_reset");
  endtask

  task automatic test_reset_mid_handshake();
    frame_data[0] = 8'hF1;
    send_frame(1);
    wait_req("hs");
    desc_ack = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (desc_req !== 1'b0 || desc_len !== '0 || desc_base !== '0) begin
      errors++;
      $display("FAIL hs_reset: desc_req=%b desc_len=%0d desc_base=%0d required 0 0 0",
               desc_req, desc_len, desc_base);
    end
    tick();
    tick();
    wq_addr.delete();
    wq_data.delete();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_stale_ack: s_ready=%b required 0", s_ready);
    end
    desc_ack = 1'b0;
    tick();
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_ack_drop_edge1: s_ready=%b required 0", s_ready);
    end
    tick();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL hs_ack_drop_edge2: s_ready=%b required 1", s_ready);
    end
    frame_data[0] = 8'h9A;
    send_frame(1);
    reader(10'd0, 3'd1, 1'b0, "hs_next");
    check_writes(10'd0, 1, "hs_next");
  endtask

  initial begin
    tick();
    test_reset();
    test_frame();
    test_truncation();
    test_backpressure();
    test_wrap();
    test_reset_mid_frame();
    test_reset_mid_handshake();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
